// File: rtl/scan_chain_controller.sv
// scan_chain_controller: host-side master for the CSR serial scan chain.
// Each transaction shifts NUM_WORDS x WIDTH bits, LSB first. Host words come in
// on a valid/ready stream and the chain's previous contents go out on another.
// WIDTH must be at least 2.
// Optional feature macro: SCAN_PARITY_EN adds cap_parity, the XOR of every
// scan_out bit captured during the transaction.
module scan_chain_controller #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned NUM_WORDS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             scan_enable,
    output logic             scan_in,
    input  logic             scan_out,
`ifdef SCAN_PARITY_EN
    output logic             cap_parity,
`endif
    output logic             processor_enable
);

    localparam int unsigned BitCntW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned WordCntW = $clog2(NUM_WORDS + 1);

    localparam logic [BitCntW-1:0]  LastBit  = BitCntW'(WIDTH - 1);
    localparam logic [WordCntW-1:0] LastWord = WordCntW'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StEmit,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     tx_q;
    logic [WIDTH-1:0]     rx_q;
    logic [WIDTH-1:0]     out_data_q;
    logic [BitCntW-1:0]   bit_cnt_q;
    logic [WordCntW-1:0]  word_cnt_q;
    logic [WIDTH-1:0]     rx_shift;

    // scan_out enters at the MSB so bit i ends up holding shift cycle i's sample
    assign rx_shift = {scan_out, rx_q[WIDTH-1:1]};
    assign out_data = out_data_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_d          = state_q;
        busy             = 1'b1;
        done             = 1'b0;
        in_ready         = 1'b0;
        out_valid        = 1'b0;
        scan_enable      = 1'b0;
        scan_in          = 1'b0;
        processor_enable = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy             = 1'b0;
                processor_enable = 1'b1;
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                scan_enable = 1'b1;
                scan_in     = tx_q[0];
                if (bit_cnt_q == LastBit) begin
                    state_d = StEmit;
                end
            end
            StEmit: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = (word_cnt_q == LastWord) ? StDone : StLoad;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Word buffers and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_q       <= '0;
            rx_q       <= '0;
            out_data_q <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        word_cnt_q <= '0;
                    end
                end
                StLoad: begin
                    if (in_valid) begin
                        tx_q      <= in_data;
                        bit_cnt_q <= '0;
                    end
                end
                StShift: begin
                    tx_q      <= tx_q >> 1;
                    rx_q      <= rx_shift;
                    bit_cnt_q <= bit_cnt_q + BitCntW'(1);
                    if (bit_cnt_q == LastBit) begin
                        out_data_q <= rx_shift;
                    end
                end
                StEmit: begin
                    if (out_ready) begin
                        word_cnt_q <= word_cnt_q + WordCntW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SCAN_PARITY_EN
    logic parity_q;

    // Running XOR of captured chain bits, cleared when a start is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            parity_q <= 1'b0;
        end else if (state_q == StShift) begin
            parity_q <= parity_q ^ scan_out;
        end
    end

    assign cap_parity = parity_q;
`endif

endmodule

// File: tb/tb_scan_chain_controller.sv
// Bench for scan_chain_controller: a 64-bit chain model driven by the DUT,
// directed and randomized transactions, with a word-level reference model in
// which each transaction returns the words sent by the previous one.
module tb_scan_chain_controller;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned NUM_WORDS = 8;
    localparam int unsigned CHAIN     = WIDTH * NUM_WORDS;
    localparam int unsigned BUDGET    = 4000;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             scan_enable;
    logic             scan_in;
    logic             scan_out;
    logic             processor_enable;
`ifdef SCAN_PARITY_EN
    logic             cap_parity;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [CHAIN-1:0] chain;
    logic             preload;
    logic [CHAIN-1:0] preload_val;

    logic [WIDTH-1:0] tx_words   [NUM_WORDS];
    logic [WIDTH-1:0] exp_words  [NUM_WORDS];
    logic [WIDTH-1:0] prev_words [NUM_WORDS];

    always #5 clk = ~clk;

    scan_chain_controller #(
        .WIDTH     (WIDTH),
        .NUM_WORDS (NUM_WORDS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .scan_enable      (scan_enable),
        .scan_in          (scan_in),
        .scan_out         (scan_out),
`ifdef SCAN_PARITY_EN
        .cap_parity       (cap_parity),
`endif
        .processor_enable (processor_enable)
    );

    // Chain model: shifts toward the tail on each enabled edge, scan_in at the head
    always @(posedge clk) begin
        if (preload) begin
            chain <= preload_val;
        end else if (scan_enable) begin
            chain <= {scan_in, chain[CHAIN-1:1]};
        end
    end

    assign scan_out = chain[0];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload_chain(input logic [CHAIN-1:0] v);
        @(negedge clk);
        preload     = 1'b1;
        preload_val = v;
        @(negedge clk);
        preload     = 1'b0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            prev_words[i] = v[i*WIDTH +: WIDTH];
        end
    endtask

    // One full transaction; drives streams at negedges and checks outputs there
    task automatic run_txn(input bit directed, input bit rnd, input bit poke_start);
        int               in_idx, out_idx, se_cnt, done_cnt, in_hold, out_hold, n;
        bit               in_armed, out_armed, poked, finished;
        logic [CHAIN-1:0] chain_snap;
        logic             exp_par;
        in_idx = 0; out_idx = 0; se_cnt = 0; done_cnt = 0; in_hold = 0; out_hold = 0;
        in_armed = 0; out_armed = 0; poked = 0; finished = 0; n = 0;
        chain_snap = chain;
        exp_par = 1'b0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            exp_words[i] = prev_words[i];
            exp_par      = exp_par ^ (^prev_words[i]);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef SCAN_PARITY_EN
        chk("parity_cleared", 64'(cap_parity), 64'(0));
`endif
        while (!finished) begin
            if (n > BUDGET) begin
                chk("timeout_waiting_done", 64'(done), 64'(1));
                break;
            end
            chk("busy_high", 64'(busy), 64'(1));
            chk("proc_en_low", 64'(processor_enable), 64'(0));
            chk("one_phase", 64'($countones({in_ready, out_valid, scan_enable, done}) <= 1),
                64'(1));
            if (!scan_enable) chk("scan_in_idle", 64'(scan_in), 64'(0));
            if (scan_enable) se_cnt++;

            start = 1'b0;
            if (poke_start && scan_enable && !poked) begin
                start = 1'b1;
                poked = 1;
            end

            if (in_ready) begin
                chk("in_not_extra", 64'(in_idx < NUM_WORDS), 64'(1));
                if (!in_armed) begin
                    in_armed   = 1;
                    chain_snap = chain;
                    in_hold    = (directed && in_idx == 2) ? 3 :
                                 (rnd ? int'($urandom_range(0, 2)) : 0);
                end else begin
                    chk("stall_no_shift", chain, chain_snap);
                end
                if (in_hold > 0) begin
                    in_hold--;
                    in_valid = 1'b0;
                    chk("stall_scan_en", 64'(scan_enable), 64'(0));
                end else begin
                    in_valid = 1'b1;
                    in_data  = tx_words[in_idx % NUM_WORDS];
                    in_idx++;
                    in_armed = 0;
                end
            end else begin
                in_valid = 1'b0;
                in_data  = WIDTH'($urandom);
            end

            if (out_valid) begin
                chk("out_not_extra", 64'(out_idx < NUM_WORDS), 64'(1));
                if (!out_armed) begin
                    out_armed = 1;
                    out_hold  = (directed && out_idx == 4) ? 5 :
                                (rnd ? int'($urandom_range(0, 3)) : 0);
                end
                chk("out_data", 64'(out_data), 64'(exp_words[out_idx % NUM_WORDS]));
                if (out_hold > 0) begin
                    out_hold--;
                    out_ready = 1'b0;
                    chk("bp_in_ready", 64'(in_ready), 64'(0));
                    chk("bp_scan_en", 64'(scan_enable), 64'(0));
                end else begin
                    out_ready = 1'b1;
                    out_idx++;
                    out_armed = 0;
                end
            end else begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            end

            if (done) begin
                done_cnt++;
                finished = 1;
                if (!directed && !rnd)
                    chk("latency", 64'(n + 1), 64'(NUM_WORDS * (WIDTH + 2) + 1));
                chk("words_in", 64'(in_idx), 64'(NUM_WORDS));
                chk("words_out", 64'(out_idx), 64'(NUM_WORDS));
                chk("shift_cycles", 64'(se_cnt), 64'(CHAIN));
`ifdef SCAN_PARITY_EN
                chk("parity_at_done", 64'(cap_parity), 64'(exp_par));
`endif
            end
            @(negedge clk);
            n++;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_proc_en", 64'(processor_enable), 64'(1));
        for (int i = 0; i < 3; i++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        chk("done_pulses", 64'(done_cnt), 64'(1));
        for (int i = 0; i < NUM_WORDS; i++) prev_words[i] = tx_words[i];
    endtask

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        preload = 1'b0; preload_val = '0;

        // Reset values
        #12;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_scan_en", 64'(scan_enable), 64'(0));
        chk("rst_scan_in", 64'(scan_in), 64'(0));
        chk("rst_proc_en", 64'(processor_enable), 64'(1));
        @(negedge clk);
        rst = 1'b1;

        // Round trip: zeros back, then the first transaction's words back
        preload_chain('0);
        for (int i = 0; i < NUM_WORDS; i++) tx_words[i] = WIDTH'(8'h11 * (i + 1));
        run_txn(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < NUM_WORDS; i++) tx_words[i] = 8'hA5;
        run_txn(1'b1, 1'b0, 1'b1);

        // Randomized words and stalls
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < NUM_WORDS; i++) tx_words[i] = WIDTH'($urandom);
            run_txn(1'b0, 1'b1, t[0]);
        end

        // Asynchronous reset in the middle of a shift
        @(negedge clk);
        start = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!scan_enable && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_test_in_shift", 64'(scan_enable), 64'(1));
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_scan_en", 64'(scan_enable), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_proc_en", 64'(processor_enable), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;

        // Recovery after reset with a known chain
        preload_chain(64'h0123_4567_89AB_CDEF);
        for (int i = 0; i < NUM_WORDS; i++) tx_words[i] = WIDTH'($urandom);
        run_txn(1'b0, 1'b0, 1'b0);

`ifdef SCAN_PARITY_EN
        preload_chain(64'h01);
        run_txn(1'b0, 1'b1, 1'b0);
        chk("parity_01", 64'(cap_parity), 64'(1));
        preload_chain(64'h03);
        run_txn(1'b0, 1'b0, 1'b0);
        chk("parity_03", 64'(cap_parity), 64'(0));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/scan_chain_controller.md
Name: scan_chain_controller

Overview:
Host-side master for the CSR block's serial scan chain: drives scan_enable/scan_in, captures scan_out, and converts the serial chain into word-wide streams.
- Each transaction shifts NUM_WORDS x WIDTH bits.
- Host words go in through a valid/ready stream; the chain's previous contents come out through a second valid/ready stream.
- Holds the processor (processor_enable low) while the chain is being shifted.

Parameters:
WIDTH, 8, bits per word (matches CSR register width)
NUM_WORDS, 8, words per transaction; chain length = NUM_WORDS*WIDTH

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  begin transaction; sampled only in IDLE
busy  output  1  high from the cycle after start is accepted through the DONE cycle
done  output  1  one-cycle pulse at end of transaction
in_data  input  WIDTH  word to shift into chain
in_valid  input  1  in_data valid
in_ready  output  1  controller accepts in_data
out_data  output  WIDTH  word captured from scan_out
out_valid  output  1  out_data valid
out_ready  input  1  host accepts out_data
scan_enable  output  1  chain shift enable
scan_in  output  1  serial data to chain head
scan_out  input  1  serial data from chain tail
processor_enable  output  1  low while busy

Behaviour:
- Reset (rst=0, asynchronous): state IDLE.
  - busy=0, done=0, in_ready=0, out_valid=0, out_data=0.
  - scan_enable=0, scan_in=0, processor_enable=1.
  - Word and bit counters = 0.
- IDLE:
  - start=1 -> LOAD next cycle; busy=1; processor_enable=0; word_cnt=0.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data into tx buffer, bit_cnt=0, go to SHIFT.
  - in_valid low stalls indefinitely with scan_enable=0.
- SHIFT: lasts exactly WIDTH consecutive cycles.
  - scan_enable=1; scan_in=tx[0] (LSB first).
  - Each cycle: tx shifts right; rx shifts right with scan_out entering the MSB.
  - After WIDTH cycles, rx bit i = scan_out sampled in shift cycle i. scan_out is sampled in the same cycle scan_enable is high, i.e. the value present before that clock edge.
  - After the last shift cycle: out_data=rx, out_valid=1, go to EMIT.
- EMIT:
  - scan_enable=0; hold out_valid and out_data until out_ready.
  - On handshake: out_valid=0, word_cnt++.
  - word_cnt reaching NUM_WORDS -> DONE; otherwise -> LOAD.
- DONE: single cycle.
  - done=1, busy=1.
  - Next cycle: IDLE, busy=0, processor_enable=1.
- Invariants:
  - scan_enable asserted only in SHIFT; scan_in=0 outside SHIFT.
  - in_ready only in LOAD; out_valid only in EMIT.
  - out_data retains its last value outside EMIT.
- start while busy: ignored, no effect.
- Minimum latency, no stalls: done asserted NUM_WORDS*(WIDTH+2)+1 cycles after the start-sampling edge. Each word takes 1 LOAD + WIDTH SHIFT + 1 EMIT cycles.
- Ordering: the chain acts as a NUM_WORDS*WIDTH-bit FIFO. Words sent in transaction N come back, in the same order and bit-exact, as the out words of transaction N+1.
- Reset mid-operation: controller returns to reset values immediately. A partial shift leaves chain contents undefined; the host must re-run a full transaction.

Optional Feature:
SCAN_PARITY_EN
- Defined: adds output cap_parity [1 bit].
  - Reset value 0.
  - Running XOR of every scan_out bit captured during SHIFT, cleared when start is accepted.
  - Value is final and stable from the DONE cycle until the next accepted start.
- Undefined: port absent, no parity logic.

Test Plan:
- Reset check: assert rst=0 mid-SHIFT without a clock edge -> scan_enable=0, busy=0, in_ready=0, out_valid=0, processor_enable=1 immediately.
- Round trip (WIDTH=8, NUM_WORDS=8, 64-bit chain model preloaded to 0):
  - Transaction 1 sends 0x11,0x22,...,0x88 -> out words all 0x00.
  - Transaction 2 sends 0xA5 x8 -> out words 0x11,0x22,...,0x88 in order.
  - Exactly 64 scan_enable cycles per transaction; done 81 cycles after start with no stalls.
- Input stall: in_valid low 3 cycles in LOAD -> scan_enable=0 for those cycles; no chain shift; the following out word is still correct.
- Output backpressure: out_ready low 5 cycles in EMIT -> out_valid=1 held, out_data stable, in_ready=0, scan_enable=0; the transaction then completes correctly.
- Busy handling:
  - start pulsed during SHIFT -> ignored; exactly one done pulse per transaction.
  - processor_enable=0 from busy rise through the DONE cycle; 1 afterwards.
- With SCAN_PARITY_EN: chain preloaded with 0x01 in word 0, all other words 0 -> cap_parity=1 at done. A second transaction preloaded with 0x03 -> cap_parity=0.
